// File: rtl/application_selector_led_pio.sv
// application_selector_led_pio: Avalon-MM output PIO driving board LEDs.
// Output data latch with atomic set/clear, plus a per-bit hardware blink
// engine clocked by a programmable period counter.
//
// Build option: define LED_PIO_ACTIVE_LOW_EN for boards whose LEDs light on
// a low pin level. Only the out_port register is inverted; DATA and every
// readback stay in logical sense (1 = LED on).
//
// Bus handshake: a write is accepted on any clk edge where chipselect is high
// and write_n is low (no wait states). readdata is registered every edge from
// the address mux, independent of chipselect, giving a fixed 1-cycle read
// latency.
//
// Register map (word address):
//   0 DATA       RW  LED data latch
//   1 STATUS     RO  bit0 = blink phase
//   2 BLINK_MASK RW  bits that blink
//   3 PERIOD     RW  blink half-period minus one (0 disables blinking)
//   4 OUTSET     WO  data |= writedata
//   5 OUTCLEAR   WO  data &= ~writedata
//   6,7 reserved
module application_selector_led_pio #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       PERIOD_W    = 24,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_PERIOD   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

`ifdef LED_PIO_ACTIVE_LOW_EN
  localparam logic [WIDTH-1:0] OUT_RESET = ~RESET_VALUE;
`else
  localparam logic [WIDTH-1:0] OUT_RESET = RESET_VALUE;
`endif

  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    data_d;
  logic [WIDTH-1:0]    blink_mask_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic                phase_q;
  logic [31:0]         readdata_q;
  logic [31:0]         readdata_d;
  logic [WIDTH-1:0]    out_port_q;
  logic [WIDTH-1:0]    out_int;

  logic                wr;
  logic                wr_data;
  logic                wr_mask;
  logic                wr_period;
  logic                wr_outset;
  logic                wr_outclear;
  logic [WIDTH-1:0]    wd_width;
  logic [PERIOD_W-1:0] wd_period;

  // Only the low WIDTH / PERIOD_W bits of writedata are meaningful.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wd_width    = writedata[WIDTH-1:0];
  assign wd_period   = writedata[PERIOD_W-1:0];

  assign wr          = chipselect & ~write_n;
  assign wr_data     = wr && (address == ADDR_DATA);
  assign wr_mask     = wr && (address == ADDR_MASK);
  assign wr_period   = wr && (address == ADDR_PERIOD);
  assign wr_outset   = wr && (address == ADDR_OUTSET);
  assign wr_outclear = wr && (address == ADDR_OUTCLEAR);

  // Next value of the data latch: plain write, atomic set, or atomic clear.
  always_comb begin
    data_d = data_q;
    if (wr_data) begin
      data_d = wd_width;
    end else if (wr_outset) begin
      data_d = data_q | wd_width;
    end else if (wr_outclear) begin
      data_d = data_q & ~wd_width;
    end
  end

  // Data latch and blink mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q       <= RESET_VALUE;
      blink_mask_q <= '0;
    end else begin
      data_q <= data_d;
      if (wr_mask) begin
        blink_mask_q <= wd_width;
      end
    end
  end

  // Blink engine: a PERIOD write restarts the countdown with phase 0; a zero
  // period parks the engine; otherwise phase toggles every period+1 cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else if (wr_period) begin
      period_q <= wd_period;
      cnt_q    <= wd_period;
      phase_q  <= 1'b0;
    end else if (period_q == '0) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q    <= period_q;
      phase_q  <= ~phase_q;
    end else begin
      cnt_q    <= cnt_q - PERIOD_W'(1);
    end
  end

  // Read mux; unused upper bits and write-only/reserved words read as zero.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:   readdata_d[WIDTH-1:0]    = data_q;
      ADDR_STATUS: readdata_d[0]            = phase_q;
      ADDR_MASK:   readdata_d[WIDTH-1:0]    = blink_mask_q;
      ADDR_PERIOD: readdata_d[PERIOD_W-1:0] = period_q;
      default:     readdata_d               = '0;
    endcase
  end

  // Registered read data, updated every edge regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  // Blinking bits are forced off while phase is high.
  assign out_int = data_q & ~(blink_mask_q & {WIDTH{phase_q}});

  // Registered LED drive, inverted for active-low boards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port_q <= OUT_RESET;
    end else begin
`ifdef LED_PIO_ACTIVE_LOW_EN
      out_port_q <= ~out_int;
`else
      out_port_q <= out_int;
`endif
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_port_q;

endmodule
